subuf7_seq: RTL and testbench
=============================

// Module: subuf7_seq
// PURPOSE
//  Multi-cycle subtractor c = a - b for the 7-bit unsigned float format (3-bit exp [6:4], 4-bit mant [3:0]).
//  The value is 1.mmmm * 2^e, with an implicit leading 1 and exponents in any order (ea != eb allowed).
//  The block inverts the equal-exponent adder; it aligns and normalizes one bit per clock under an FSM.
//  Sits beside the adder in the float datapath and uses a start/busy/done handshake.
// PARAMETERS
//  EW  3  exponent width (bits [EW+MW-1:MW])
//  MW  4  stored mantissa width; working mantissa is MW+2 bits = {1'b1, mant, 1'b0 guard}
// PORTS
//  clk    in   1      single clock, rising edge
//  rst_n  in   1      asynchronous active-low reset
//  start  in   1      request; sampled only when busy=0
//  a      in   EW+MW  minuend (captured on the accepting edge)
//  b      in   EW+MW  subtrahend (captured on the accepting edge)
//  busy   out  1      high from the cycle after acceptance until done
//  done   out  1      one-cycle pulse; c and flags are valid from this cycle on
//  c      out  EW+MW  result, registered, held until the next accepted start
//  zero   out  1      a == b, so c = 0
//  neg    out  1      a < b (unsigned compare of the 7-bit words), so c = 0
//  uflow  out  1      result is below 1.0*2^0 after normalization, so c = 0
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy, done, c, zero, neg, uflow all 0; internal regs 0.
//  Reset mid-operation aborts at once. No done pulse follows.
//  States: IDLE, ALIGN, SUB, NORM, DONE.
//  IDLE, start=1: latch a, b; d = ea-eb; ma = {1,a[3:0],0}, mb = {1,b[3:0],0}; er = ea.
//    a < b  -> DONE with neg=1, c=0.
//    a == b -> DONE with zero=1, c=0.
//    d == 0 -> SUB.
//    else   -> ALIGN.
//  ALIGN: mb <= mb >> 1, count--; exactly d cycles, then SUB. Bits shifted out are lost (truncate).
//  SUB: m <= ma - mb (6-bit, cannot go negative since a > b).
//    m[5]=1 -> DONE.
//    else   -> NORM.
//  NORM, each cycle:
//    er == 0 -> DONE with uflow=1, c=0.
//    else    -> m <= m << 1; er <= er-1; if the new m[5]=1 -> DONE.
//  DONE entry (normal path): c <= {er, m[4:1]} (guard bit dropped, no rounding); flags cleared.
//  DONE: done=1 and busy=0 for exactly one cycle, then IDLE. start is not accepted in DONE.
//  start while busy=1, or in DONE: ignored. a and b may change freely after the accepting edge.
//  Latency: count the accepting edge as edge 1.
//    Normal path: done is high after edge d+n+2, where n = NORM shifts.
//    neg/zero path: done is high after edge 1.
//  Flags are mutually exclusive. At most one of zero/neg/uflow is 1 per result.
//  d = 7 > working width: mb becomes 0 after 6 shifts; ALIGN still runs 7 cycles; result = a.
//  Exponent overflow cannot occur, since the result never exceeds a.
// TESTING
//  a=100_1000, b=100_0000 -> d=0, n=1; c=011_0000, flags 0, done after edge 3.
//  a=101_0000, b=100_1000 -> d=1, n=2; c=011_0000 (32-24=8), done after edge 5.
//  a=b=110_0101 -> zero=1, c=0, done after edge 1. a=100_0000, b=101_0000 -> neg=1, c=0.
//  a=000_1000, b=000_0000 -> diff 0.5 with er=0 -> uflow=1, c=0.
//  a=111_0000, b=000_1111 -> 7 ALIGN cycles; c=111_0000, done after edge 9.
//  start pulsed during busy, and rst_n=0 during ALIGN -> no extra op; all outputs 0, IDLE, no done.

Source files
------------

// File: rtl/subuf7_seq.sv
// subuf7_seq: multi-cycle subtractor c = a - b for the 7-bit unsigned float
// format (exp in the upper EW bits, stored mantissa in the lower MW bits,
// value 1.mmmm * 2^e). The smaller operand is aligned one bit per clock, the
// working mantissas are subtracted, then the result is normalized one bit per
// clock. Handshake is start/busy/done; results are registered and held.
module subuf7_seq #(
  parameter int EW = 3,
  parameter int MW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [EW+MW-1:0] a,
  input  logic [EW+MW-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [EW+MW-1:0] c,
  output logic             zero,
  output logic             neg,
  output logic             uflow
);

  // Working mantissa: {hidden 1, stored mantissa, guard bit}
  localparam int WW = MW + 2;
  localparam logic [EW-1:0] E_ONE  = EW'(1);
  localparam logic [EW-1:0] E_ZERO = '0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    SUB   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state_r;
  logic [WW-1:0] ma_r;
  logic [WW-1:0] mb_r;
  logic [WW-1:0] m_r;
  logic [EW-1:0] er_r;
  logic [EW-1:0] cnt_r;

  logic [EW-1:0] ea_s;
  logic [EW-1:0] eb_s;
  logic [EW-1:0] d_s;
  logic [WW-1:0] diff_s;
  logic [WW-1:0] shl_s;
  logic [EW-1:0] er_dec_s;

  // Operand fields, exponent difference and the per-step datapath values.
  // Since a > b as unsigned words whenever d_s is used, ea >= eb and the
  // difference never wraps on the paths that consume it.
  always_comb begin
    ea_s     = a[EW+MW-1:MW];
    eb_s     = b[EW+MW-1:MW];
    d_s      = ea_s - eb_s;
    diff_s   = ma_r - mb_r;
    shl_s    = m_r << 1'b1;
    er_dec_s = er_r - E_ONE;
  end

  // Control FSM with registered handshake outputs and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ma_r    <= '0;
      mb_r    <= '0;
      m_r     <= '0;
      er_r    <= '0;
      cnt_r   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      c       <= '0;
      zero    <= 1'b0;
      neg     <= 1'b0;
      uflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            ma_r  <= {1'b1, a[MW-1:0], 1'b0};
            mb_r  <= {1'b1, b[MW-1:0], 1'b0};
            m_r   <= '0;
            er_r  <= ea_s;
            cnt_r <= d_s;
            c     <= '0;
            zero  <= 1'b0;
            neg   <= 1'b0;
            uflow <= 1'b0;
            if (a < b) begin
              neg     <= 1'b1;
              done    <= 1'b1;
              state_r <= DONE;
            end else if (a == b) begin
              zero    <= 1'b1;
              done    <= 1'b1;
              state_r <= DONE;
            end else if (d_s == E_ZERO) begin
              busy    <= 1'b1;
              state_r <= SUB;
            end else begin
              busy    <= 1'b1;
              state_r <= ALIGN;
            end
          end else begin
            state_r <= IDLE;
          end
        end

        ALIGN: begin
          // Truncating right shift; runs exactly d cycles even once mb is 0.
          mb_r  <= {1'b0, mb_r[WW-1:1]};
          cnt_r <= cnt_r - E_ONE;
          if (cnt_r == E_ONE) begin
            state_r <= SUB;
          end else begin
            state_r <= ALIGN;
          end
        end

        SUB: begin
          m_r <= diff_s;
          if (diff_s[WW-1]) begin
            c       <= {er_r, diff_s[WW-2:1]};
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            state_r <= NORM;
          end
        end

        NORM: begin
          if (er_r == E_ZERO) begin
            // Cannot shift further without going below 2^0.
            uflow   <= 1'b1;
            c       <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            m_r  <= shl_s;
            er_r <= er_dec_s;
            if (shl_s[WW-1]) begin
              c       <= {er_dec_s, shl_s[WW-2:1]};
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= DONE;
            end else begin
              state_r <= NORM;
            end
          end
        end

        DONE: begin
          // start is deliberately not sampled here.
          state_r <= IDLE;
        end

        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subuf7_seq.sv
// Directed, table-driven bench for subuf7_seq with hand-computed results,
// plus sequences for start-while-busy and reset during ALIGN.
module tb_subuf7_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [6:0] a;
  logic [6:0] b;
  logic       busy;
  logic       done;
  logic [6:0] c;
  logic       zero;
  logic       neg;
  logic       uflow;

  int n_pass;
  int n_total;

  subuf7_seq #(.EW(3), .MW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .c     (c),
    .zero  (zero),
    .neg   (neg),
    .uflow (uflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] va;
    logic [6:0] vb;
    logic [6:0] ec;
    logic       ez;
    logic       en;
    logic       eu;
    int         elat;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Launch one operation and return the accepting-edge-relative latency.
  task automatic launch(input logic [6:0] va, input logic [6:0] vb, output int lat, output int busy1);
    @(negedge clk);
    a = va;
    b = vb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 7'h00;
    b = 7'h00;
    lat = 1;
    busy1 = int'(busy);
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_vec(input int i);
    int lat;
    int busy1;
    launch(vecs[i].va, vecs[i].vb, lat, busy1);
    chk($sformatf("v%0d latency", i), lat, vecs[i].elat);
    chk($sformatf("v%0d busy_after_accept", i), busy1, (vecs[i].elat > 1) ? 1 : 0);
    chk($sformatf("v%0d c", i), int'(c), int'(vecs[i].ec));
    chk($sformatf("v%0d flags", i), int'({zero, neg, uflow}), int'({vecs[i].ez, vecs[i].en, vecs[i].eu}));
    chk($sformatf("v%0d busy_at_done", i), int'(busy), 0);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d done_pulse", i), int'(done), 0);
    chk($sformatf("v%0d c_held", i), int'(c), int'(vecs[i].ec));
  endtask

  initial begin
    int lat;
    int busy1;
    int extra_done;
    int extra_busy;

    n_pass = 0;
    n_total = 0;
    // a, b, c, zero, neg, uflow, latency
    vecs[0] = '{7'b100_1000, 7'b100_0000, 7'b011_0000, 1'b0, 1'b0, 1'b0, 3};
    vecs[1] = '{7'b101_0000, 7'b100_1000, 7'b011_0000, 1'b0, 1'b0, 1'b0, 5};
    vecs[2] = '{7'b110_0101, 7'b110_0101, 7'b000_0000, 1'b1, 1'b0, 1'b0, 1};
    vecs[3] = '{7'b100_0000, 7'b101_0000, 7'b000_0000, 1'b0, 1'b1, 1'b0, 1};
    vecs[4] = '{7'b000_1000, 7'b000_0000, 7'b000_0000, 1'b0, 1'b0, 1'b1, 3};
    vecs[5] = '{7'b111_0000, 7'b000_1111, 7'b111_0000, 1'b0, 1'b0, 1'b0, 9};
    vecs[6] = '{7'b011_1111, 7'b010_0000, 7'b011_0111, 1'b0, 1'b0, 1'b0, 3};
    vecs[7] = '{7'b010_0001, 7'b010_0000, 7'b000_0000, 1'b0, 1'b0, 1'b1, 5};
    vecs[8] = '{7'b110_0001, 7'b110_0000, 7'b010_0000, 1'b0, 1'b0, 1'b0, 6};
    vecs[9] = '{7'b011_0010, 7'b011_0011, 7'b000_0000, 1'b0, 1'b1, 1'b0, 1};

    rst_n = 1'b0;
    start = 1'b0;
    a = 7'h00;
    b = 7'h00;
    #12;
    chk("reset outputs", int'({busy, done, c, zero, neg, uflow}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i);

    // start pulsed repeatedly while busy must not launch a second operation.
    @(negedge clk);
    a = 7'b111_0000;
    b = 7'b000_1111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a = 7'b101_0000;
      b = 7'b100_1000;
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    lat = 5;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("busy_start latency", lat, 9);
    chk("busy_start c", int'(c), int'(7'b111_0000));
    extra_done = 0;
    extra_busy = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) extra_done++;
      if (busy) extra_busy++;
    end
    chk("busy_start no_extra_done", extra_done, 0);
    chk("busy_start no_extra_busy", extra_busy, 0);

    // Reset asserted in ALIGN aborts at once; no done afterwards.
    @(negedge clk);
    a = 7'b111_0000;
    b = 7'b000_1111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort busy_before_reset", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort outputs_zero", int'({busy, done, c, zero, neg, uflow}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    extra_done = 0;
    extra_busy = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) extra_done++;
      if (busy) extra_busy++;
    end
    chk("abort no_done", extra_done, 0);
    chk("abort idle", extra_busy, 0);

    // Recovery: a normal operation still works after the abort.
    launch(7'b101_0000, 7'b100_1000, lat, busy1);
    chk("recover latency", lat, 5);
    chk("recover c", int'(c), int'(7'b011_0000));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
